axi4_burst_master: RTL and testbench

//  Command-driven AXI4 master; sits directly upstream of the axi4 memory slave and drives its AW/W/B/AR/R ports.

---
 rtl/axi4_burst_master.sv | 244 ++++++++++++++++++++++++
 tb/tb_axi4_burst_master.sv | 420 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_burst_master.sv
// axi4_burst_master: turns one write/read command into one AXI4 INCR burst, one transaction at a time.
// Optional feature macro AXI4_MASTER_ERR_STICKY_EN adds the err_sticky / err_clr sticky error flag.
module axi4_burst_master #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 16
) (
    input  logic                  ACLK,
    input  logic                  ARESET,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [ADDR_WIDTH-1:0] cmd_addr,
    input  logic [7:0]            cmd_len,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  rd_last,
    input  logic                  rd_ready,
    output logic                  done_valid,
    output logic [1:0]            done_resp,
    output logic [ADDR_WIDTH-1:0] AWADDR,
    output logic [7:0]            AWLEN,
    output logic [2:0]            AWSIZE,
    output logic                  AWVALID,
    input  logic                  AWREADY,
    output logic [DATA_WIDTH-1:0] WDATA,
    output logic                  WVALID,
    output logic                  WLAST,
    input  logic                  WREADY,
    input  logic [1:0]            BRESP,
    input  logic                  BVALID,
    output logic                  BREADY,
    output logic [ADDR_WIDTH-1:0] ARADDR,
    output logic [7:0]            ARLEN,
    output logic [2:0]            ARSIZE,
    output logic                  ARVALID,
    input  logic                  ARREADY,
    input  logic [DATA_WIDTH-1:0] RDATA,
    input  logic [1:0]            RRESP,
    input  logic                  RVALID,
    input  logic                  RLAST,
    output logic                  RREADY
`ifdef AXI4_MASTER_ERR_STICKY_EN
    ,
    output logic                  err_sticky,
    input  logic                  err_clr
`endif
);

    localparam int unsigned BYTES_PER_BEAT = DATA_WIDTH / 8;
    localparam int unsigned ADDR_LSB       = $clog2(BYTES_PER_BEAT);
    localparam logic [2:0]  AXSIZE         = 3'(ADDR_LSB);
    localparam logic [ADDR_WIDTH-1:0] ADDR_MASK = ~ADDR_WIDTH'((1 << ADDR_LSB) - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_AW,
        S_W,
        S_B,
        S_AR,
        S_R
    } state_t;

    state_t                  state_q, state_d;
    logic                    cmd_ready_q, cmd_ready_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [7:0]              len_q, len_d;
    logic [7:0]              beat_cnt_q, beat_cnt_d;
    logic                    awvalid_q, awvalid_d;
    logic                    arvalid_q, arvalid_d;
    logic                    bready_q, bready_d;
    logic                    done_valid_q, done_valid_d;
    logic [1:0]              done_resp_q, done_resp_d;
    logic [1:0]              resp_acc_q, resp_acc_d;

    logic                    in_w, in_r;
    logic                    w_hs, r_hs;
    logic                    last_beat;
    logic [1:0]              resp_max;

    // Data channels are zero-latency pass-throughs, gated so nothing leaks outside W / R.
    assign in_w     = (state_q == S_W);
    assign in_r     = (state_q == S_R);
    assign WVALID   = in_w & wr_valid;
    assign WDATA    = wr_data;
    assign WLAST    = in_w & (beat_cnt_q == len_q);
    assign wr_ready = in_w & WREADY;
    assign RREADY   = in_r & rd_ready;
    assign rd_valid = in_r & RVALID;
    assign rd_data  = RDATA;
    assign rd_last  = in_r & RLAST;
    assign w_hs     = WVALID & WREADY;
    assign r_hs     = RVALID & RREADY;

    assign cmd_ready  = cmd_ready_q;
    assign AWADDR     = addr_q;
    assign ARADDR     = addr_q;
    assign AWLEN      = len_q;
    assign ARLEN      = len_q;
    assign AWSIZE     = AXSIZE;
    assign ARSIZE     = AXSIZE;
    assign AWVALID    = awvalid_q;
    assign ARVALID    = arvalid_q;
    assign BREADY     = bready_q;
    assign done_valid = done_valid_q;
    assign done_resp  = done_resp_q;

    // Next-state and registered-output logic.
    always_comb begin
        state_d      = state_q;
        cmd_ready_d  = cmd_ready_q;
        addr_d       = addr_q;
        len_d        = len_q;
        beat_cnt_d   = beat_cnt_q;
        awvalid_d    = awvalid_q;
        arvalid_d    = arvalid_q;
        bready_d     = bready_q;
        done_valid_d = 1'b0;
        done_resp_d  = done_resp_q;
        resp_acc_d   = resp_acc_q;
        last_beat    = (beat_cnt_q == len_q);
        resp_max     = (RRESP > resp_acc_q) ? RRESP : resp_acc_q;

        case (state_q)
            S_IDLE: begin
                cmd_ready_d = 1'b1;
                if (cmd_valid && cmd_ready_q) begin
                    cmd_ready_d = 1'b0;
                    addr_d      = cmd_addr & ADDR_MASK;
                    len_d       = cmd_len;
                    beat_cnt_d  = 8'd0;
                    resp_acc_d  = 2'b00;
                    if (cmd_write) begin
                        state_d   = S_AW;
                        awvalid_d = 1'b1;
                    end else begin
                        state_d   = S_AR;
                        arvalid_d = 1'b1;
                    end
                end
            end
            S_AW: begin
                if (awvalid_q && AWREADY) begin
                    awvalid_d = 1'b0;
                    state_d   = S_W;
                end
            end
            S_W: begin
                if (w_hs) begin
                    beat_cnt_d = beat_cnt_q + 8'd1;
                    if (last_beat) begin
                        state_d  = S_B;
                        bready_d = 1'b1;
                    end
                end
            end
            S_B: begin
                if (BVALID && bready_q) begin
                    bready_d     = 1'b0;
                    done_valid_d = 1'b1;
                    done_resp_d  = BRESP;
                    state_d      = S_IDLE;
                end
            end
            S_AR: begin
                if (arvalid_q && ARREADY) begin
                    arvalid_d = 1'b0;
                    state_d   = S_R;
                end
            end
            S_R: begin
                if (r_hs) begin
                    beat_cnt_d = beat_cnt_q + 8'd1;
                    resp_acc_d = resp_max;
                    // A misplaced or missing RLAST ends the burst with SLVERR.
                    if (last_beat || RLAST) begin
                        done_valid_d = 1'b1;
                        done_resp_d  = (last_beat != RLAST) ? 2'b10 : resp_max;
                        state_d      = S_IDLE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state_q      <= S_IDLE;
            cmd_ready_q  <= 1'b0;
            addr_q       <= '0;
            len_q        <= '0;
            beat_cnt_q   <= '0;
            awvalid_q    <= 1'b0;
            arvalid_q    <= 1'b0;
            bready_q     <= 1'b0;
            done_valid_q <= 1'b0;
            done_resp_q  <= 2'b00;
            resp_acc_q   <= 2'b00;
        end else begin
            state_q      <= state_d;
            cmd_ready_q  <= cmd_ready_d;
            addr_q       <= addr_d;
            len_q        <= len_d;
            beat_cnt_q   <= beat_cnt_d;
            awvalid_q    <= awvalid_d;
            arvalid_q    <= arvalid_d;
            bready_q     <= bready_d;
            done_valid_q <= done_valid_d;
            done_resp_q  <= done_resp_d;
            resp_acc_q   <= resp_acc_d;
        end
    end

`ifdef AXI4_MASTER_ERR_STICKY_EN
    logic err_sticky_q, err_sticky_d;

    // Set on any erroring completion; a simultaneous clear loses.
    always_comb begin
        err_sticky_d = err_sticky_q;
        if (err_clr) begin
            err_sticky_d = 1'b0;
        end
        if (done_valid_q && (done_resp_q != 2'b00)) begin
            err_sticky_d = 1'b1;
        end
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            err_sticky_q <= 1'b0;
        end else begin
            err_sticky_q <= err_sticky_d;
        end
    end

    assign err_sticky = err_sticky_q;
`endif

endmodule

// File: tb/tb_axi4_burst_master.sv
// tb_axi4_burst_master: randomized bench with a memory-backed AXI4 slave and an expected-memory reference.
module tb_axi4_burst_master;

    localparam int MEM_WORDS = 4096;

    logic        ACLK = 1'b0;
    logic        ARESET;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [15:0] cmd_addr;
    logic [7:0]  cmd_len;
    logic [31:0] wr_data, rd_data;
    logic        wr_valid, wr_ready, rd_valid, rd_last, rd_ready;
    logic        done_valid;
    logic [1:0]  done_resp;
    logic [15:0] AWADDR, ARADDR;
    logic [7:0]  AWLEN, ARLEN;
    logic [2:0]  AWSIZE, ARSIZE;
    logic        AWVALID, AWREADY, WVALID, WLAST, WREADY, BVALID, BREADY;
    logic        ARVALID, ARREADY, RVALID, RLAST, RREADY;
    logic [31:0] WDATA, RDATA;
    logic [1:0]  BRESP, RRESP;
`ifdef AXI4_MASTER_ERR_STICKY_EN
    logic        err_sticky;
    logic        err_clr;
`endif

    int vectors;
    int miscompares;

    int stall_pct;
    bit early_last_en;
    int early_last_beat;
    bit drop_last_en;

    logic [31:0] ref_mem [int];

    axi4_burst_master #(.DATA_WIDTH(32), .ADDR_WIDTH(16)) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
        .rd_data(rd_data), .rd_valid(rd_valid), .rd_last(rd_last), .rd_ready(rd_ready),
        .done_valid(done_valid), .done_resp(done_resp),
        .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WVALID(WVALID), .WLAST(WLAST), .WREADY(WREADY),
        .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RLAST(RLAST), .RREADY(RREADY)
`ifdef AXI4_MASTER_ERR_STICKY_EN
        , .err_sticky(err_sticky), .err_clr(err_clr)
`endif
    );

    always #5 ACLK = ~ACLK;

    function automatic bit rnd_rdy();
        return (int'($urandom_range(99)) >= stall_pct);
    endfunction

    function automatic int word_of(input logic [15:0] ad, input int i);
        return int'(ad >> 2) + i;
    endfunction

    // Memory slave: 16 KB window, SLVERR beyond it, random back-pressure, optional RLAST faults.
    logic [31:0] slv_mem [0:MEM_WORDS-1];
    logic [15:0] s_awaddr, s_araddr, aw_prev_addr, ar_prev_addr;
    logic [7:0]  s_awlen, s_arlen;
    logic [2:0]  s_awsize, s_arsize;
    bit          s_aw_ok, s_werr, s_bpend, s_r_act, aw_prev, ar_prev;
    int          s_wcnt, s_rcnt;
    int          order_err, wlast_err, hold_err;

    always @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            AWREADY <= 1'b0; WREADY <= 1'b0; BVALID <= 1'b0; BRESP <= 2'b00;
            ARREADY <= 1'b0; RVALID <= 1'b0; RLAST <= 1'b0; RRESP <= 2'b00; RDATA <= 32'h0;
            s_aw_ok <= 1'b0; s_werr <= 1'b0; s_bpend <= 1'b0; s_r_act <= 1'b0;
            s_wcnt <= 0; s_rcnt <= 0; aw_prev <= 1'b0; ar_prev <= 1'b0;
        end else begin
            aw_prev      <= AWVALID && !AWREADY;
            ar_prev      <= ARVALID && !ARREADY;
            aw_prev_addr <= AWADDR;
            ar_prev_addr <= ARADDR;
            if ((aw_prev && (!AWVALID || AWADDR != aw_prev_addr)) ||
                (ar_prev && (!ARVALID || ARADDR != ar_prev_addr)))
                hold_err <= hold_err + 1;

            AWREADY <= rnd_rdy();
            if (AWVALID && AWREADY) begin
                s_aw_ok <= 1'b1; s_awaddr <= AWADDR; s_awlen <= AWLEN; s_awsize <= AWSIZE;
                s_wcnt <= 0; s_werr <= 1'b0;
            end
            WREADY <= rnd_rdy();
            if (WVALID && !s_aw_ok)
                order_err <= order_err + 1;
            if (WVALID && WREADY && s_aw_ok) begin
                if (WLAST !== (s_wcnt == int'(s_awlen)))
                    wlast_err <= wlast_err + 1;
                if (word_of(s_awaddr, s_wcnt) < MEM_WORDS)
                    slv_mem[word_of(s_awaddr, s_wcnt)] <= WDATA;
                else
                    s_werr <= 1'b1;
                s_wcnt <= s_wcnt + 1;
                if (WLAST) begin
                    s_aw_ok <= 1'b0;
                    s_bpend <= 1'b1;
                end
            end
            if (s_bpend && !BVALID && rnd_rdy()) begin
                BVALID  <= 1'b1;
                BRESP   <= s_werr ? 2'b10 : 2'b00;
                s_bpend <= 1'b0;
            end
            if (BVALID && BREADY)
                BVALID <= 1'b0;

            ARREADY <= rnd_rdy();
            if (ARVALID && ARREADY) begin
                s_araddr <= ARADDR; s_arlen <= ARLEN; s_arsize <= ARSIZE;
                s_r_act <= 1'b1; s_rcnt <= 0;
            end
            if (RVALID && RREADY)
                RVALID <= 1'b0;
            if (s_r_act && (!RVALID || RREADY) && rnd_rdy()) begin
                RVALID <= 1'b1;
                if (word_of(s_araddr, s_rcnt) < MEM_WORDS) begin
                    RDATA <= slv_mem[word_of(s_araddr, s_rcnt)];
                    RRESP <= 2'b00;
                end else begin
                    RDATA <= 32'h0;
                    RRESP <= 2'b10;
                end
                if (early_last_en)
                    RLAST <= (s_rcnt == early_last_beat);
                else
                    RLAST <= !drop_last_en && (s_rcnt == int'(s_arlen));
                s_rcnt <= s_rcnt + 1;
                if (s_rcnt == int'(s_arlen) || (early_last_en && s_rcnt == early_last_beat))
                    s_r_act <= 1'b0;
            end
        end
    end

    task automatic idle_inputs();
        cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 16'h0; cmd_len = 8'h0;
        wr_valid = 1'b0; wr_data = 32'h0; rd_ready = 1'b0;
`ifdef AXI4_MASTER_ERR_STICKY_EN
        err_clr = 1'b0;
`endif
    endtask

    // One command end to end; abort_at >= 0 pulls ARESET once that many write beats have gone.
    task automatic run_txn(input bit wr, input logic [15:0] addr, input logic [7:0] len,
                           input bit thr, input int abort_at, input bit fixed,
                           input logic [31:0] fixed_data);
        logic [31:0] wdat[$];
        logic [31:0] rdv[$];
        logic        rlv[$];
        logic [15:0] a;
        logic [1:0]  got_resp, exp_resp;
        int          wbeat, cyc, nb;
        bit          acc, fin, bad, seen_done;
        a = addr & 16'hFFFC;
        for (int i = 0; i <= int'(len); i++)
            wdat.push_back(fixed ? fixed_data : $urandom);
        nb = (!wr && early_last_en) ? early_last_beat + 1 : int'(len) + 1;
        bad = 1'b0;
        for (int i = 0; i < nb; i++)
            if (word_of(a, i) >= MEM_WORDS) bad = 1'b1;
        exp_resp = (bad || (!wr && (early_last_en || drop_last_en))) ? 2'b10 : 2'b00;
        acc = 1'b0; fin = 1'b0; wbeat = 0; cyc = 0; got_resp = 2'b00;

        while (!fin && cyc < 4000) begin
            @(negedge ACLK);
            cyc++;
            if (done_valid) begin
                fin = 1'b1;
                got_resp = done_resp;
                idle_inputs();
                vectors++;
                if (cmd_ready !== 1'b0) begin
                    miscompares++;
                    $display("FAIL cmd_ready_at_done: got %b expected 0", cmd_ready);
                end
            end else begin
                if (!acc) begin
                    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_len = len;
                    if (cmd_ready) acc = 1'b1;
                end else begin
                    cmd_valid = 1'b0; cmd_addr = 16'($urandom); cmd_len = 8'($urandom);
                end
                if (wr && wbeat <= int'(len)) begin
                    wr_valid = thr ? (cyc % 3 == 0) : 1'b1;
                    wr_data  = wdat[wbeat];
                    if (abort_at >= 0 && wbeat == abort_at) begin
                        #2 ARESET = 1'b1;
                        #1;
                        vectors++;
                        if ({AWVALID, WVALID, ARVALID, BREADY, RREADY, rd_valid, done_valid,
                             cmd_ready, wr_ready} !== 9'b0) begin
                            miscompares++;
                            $display("FAIL abort_valids: got %b expected 000000000",
                                     {AWVALID, WVALID, ARVALID, BREADY, RREADY, rd_valid,
                                      done_valid, cmd_ready, wr_ready});
                        end
                        idle_inputs();
                        @(negedge ACLK);
                        @(negedge ACLK);
                        ARESET = 1'b0;
                        seen_done = 1'b0;
                        for (int k = 0; k < 6; k++) begin
                            @(negedge ACLK);
                            if (done_valid) seen_done = 1'b1;
                        end
                        vectors++;
                        if (seen_done || cmd_ready !== 1'b1) begin
                            miscompares++;
                            $display("FAIL abort_recover: done_seen=%b cmd_ready=%b expected 0/1",
                                     seen_done, cmd_ready);
                        end
                        return;
                    end
                    if (wr_valid && wr_ready) begin
                        if (word_of(a, wbeat) < MEM_WORDS) ref_mem[word_of(a, wbeat)] = wr_data;
                        wbeat++;
                    end
                end else begin
                    wr_valid = 1'b0;
                    wr_data  = $urandom;
                end
                if (!wr) begin
                    rd_ready = thr ? 1'($urandom % 2) : 1'b1;
                    if (rd_valid && rd_ready) begin
                        rdv.push_back(rd_data);
                        rlv.push_back(rd_last);
                    end
                end else begin
                    rd_ready = 1'b0;
                end
            end
        end

        vectors++;
        if (!fin) begin
            miscompares++;
            $display("FAIL timeout: no done_valid within %0d cycles (addr %h len %0d)", cyc, addr, len);
            idle_inputs();
        end
        vectors++;
        if (got_resp !== exp_resp) begin
            miscompares++;
            $display("FAIL done_resp: addr %h len %0d got %b expected %b", addr, len, got_resp, exp_resp);
        end
        @(negedge ACLK);
        vectors++;
        if (done_valid !== 1'b0 || cmd_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL after_done: done_valid=%b cmd_ready=%b expected 0/1", done_valid, cmd_ready);
        end
        if (wr) begin
            vectors++;
            if (s_awaddr !== a || s_awlen !== len || s_awsize !== 3'd2 || wbeat != int'(len) + 1) begin
                miscompares++;
                $display("FAIL aw_fields: addr %h len %0d size %0d beats %0d expected %h %0d 2 %0d",
                         s_awaddr, s_awlen, s_awsize, wbeat, a, len, int'(len) + 1);
            end
        end else begin
            vectors++;
            if (s_araddr !== a || s_arlen !== len || s_arsize !== 3'd2 || rdv.size() != nb) begin
                miscompares++;
                $display("FAIL ar_fields: addr %h len %0d size %0d beats %0d expected %h %0d 2 %0d",
                         s_araddr, s_arlen, s_arsize, rdv.size(), a, len, nb);
            end
            for (int i = 0; i < rdv.size() && i < nb; i++) begin
                vectors++;
                if (rlv[i] !== ((i == nb - 1) && !drop_last_en) ||
                    (ref_mem.exists(word_of(a, i)) && rdv[i] !== ref_mem[word_of(a, i)])) begin
                    miscompares++;
                    $display("FAIL rd_beat%0d: data %h last %b expected %h last %b", i, rdv[i], rlv[i],
                             ref_mem.exists(word_of(a, i)) ? ref_mem[word_of(a, i)] : 32'h0,
                             (i == nb - 1) && !drop_last_en);
                end
            end
        end
        vectors++;
        if (order_err != 0 || wlast_err != 0 || hold_err != 0) begin
            miscompares++;
            $display("FAIL protocol: order %0d wlast %0d hold %0d expected 0 0 0",
                     order_err, wlast_err, hold_err);
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        ARESET = 1'b1;
        repeat (3) @(negedge ACLK);
        vectors++;
        if ({cmd_ready, AWVALID, WVALID, ARVALID, BREADY, RREADY, wr_ready, rd_valid, done_valid} !== 9'b0) begin
            miscompares++;
            $display("FAIL reset_ctrl: got %b expected 000000000",
                     {cmd_ready, AWVALID, WVALID, ARVALID, BREADY, RREADY, wr_ready, rd_valid, done_valid});
        end
        vectors++;
        if (AWADDR !== 16'h0 || ARADDR !== 16'h0 || AWLEN !== 8'h0 || ARLEN !== 8'h0 || done_resp !== 2'b00) begin
            miscompares++;
            $display("FAIL reset_fields: awaddr %h araddr %h awlen %h arlen %h resp %b expected zeros",
                     AWADDR, ARADDR, AWLEN, ARLEN, done_resp);
        end
        vectors++;
        if (AWSIZE !== 3'd2 || ARSIZE !== 3'd2) begin
            miscompares++;
            $display("FAIL reset_size: awsize %0d arsize %0d expected 2 2", AWSIZE, ARSIZE);
        end
        ARESET = 1'b0;
        @(negedge ACLK);
        vectors++;
        if (cmd_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_release_ready: got %b expected 1", cmd_ready);
        end
`ifdef AXI4_MASTER_ERR_STICKY_EN
        vectors++;
        if (err_sticky !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_sticky: got %b expected 0", err_sticky);
        end
`endif
    endtask

    task automatic test_single_write();
        stall_pct = 20;
        run_txn(1'b1, 16'h0010, 8'd0, 1'b0, -1, 1'b1, 32'hA5A5A5A5);
        run_txn(1'b0, 16'h0010, 8'd0, 1'b0, -1, 1'b0, 32'h0);
    endtask

    task automatic test_burst_rw();
        run_txn(1'b1, 16'h0100, 8'd7, 1'b0, -1, 1'b0, 32'h0);
        run_txn(1'b0, 16'h0100, 8'd7, 1'b0, -1, 1'b0, 32'h0);
    endtask

    task automatic test_out_of_range();
        run_txn(1'b0, 16'hFFF0, 8'd0, 1'b0, -1, 1'b0, 32'h0);
`ifdef AXI4_MASTER_ERR_STICKY_EN
        vectors++;
        if (err_sticky !== 1'b1) begin
            miscompares++;
            $display("FAIL sticky_set: got %b expected 1", err_sticky);
        end
        err_clr = 1'b1;
        @(negedge ACLK);
        err_clr = 1'b0;
        vectors++;
        if (err_sticky !== 1'b0) begin
            miscompares++;
            $display("FAIL sticky_clr: got %b expected 0", err_sticky);
        end
`endif
        run_txn(1'b1, 16'h3FF8, 8'd3, 1'b0, -1, 1'b0, 32'h0);
    endtask

    task automatic test_throttle();
        logic [15:0] ad;
        logic [7:0]  ln;
        for (int k = 0; k < 6; k++) begin
            stall_pct = int'($urandom_range(60));
            ad = 16'h1000 + 16'($urandom_range(255) * 16) + 16'($urandom_range(3));
            ln = 8'($urandom_range(15));
            run_txn(1'b1, ad, ln, 1'b1, -1, 1'b0, 32'h0);
            run_txn(1'b0, ad, ln, 1'b1, -1, 1'b0, 32'h0);
        end
        stall_pct = 10;
        run_txn(1'b1, 16'h2000, 8'd255, 1'b1, -1, 1'b0, 32'h0);
        run_txn(1'b0, 16'h2000, 8'd255, 1'b1, -1, 1'b0, 32'h0);
    endtask

    task automatic test_reset_mid_burst();
        stall_pct = 20;
        run_txn(1'b1, 16'h0200, 8'd7, 1'b0, 3, 1'b0, 32'h0);
        run_txn(1'b1, 16'h0200, 8'd7, 1'b0, -1, 1'b0, 32'h0);
        run_txn(1'b0, 16'h0200, 8'd7, 1'b0, -1, 1'b0, 32'h0);
    endtask

    task automatic test_rlast_faults();
        run_txn(1'b1, 16'h0300, 8'd3, 1'b0, -1, 1'b0, 32'h0);
        early_last_en = 1'b1;
        early_last_beat = 2;
        run_txn(1'b0, 16'h0300, 8'd3, 1'b0, -1, 1'b0, 32'h0);
        early_last_en = 1'b0;
        drop_last_en = 1'b1;
        run_txn(1'b0, 16'h0300, 8'd3, 1'b0, -1, 1'b0, 32'h0);
        drop_last_en = 1'b0;
        run_txn(1'b0, 16'h0300, 8'd3, 1'b0, -1, 1'b0, 32'h0);
    endtask

    task automatic test_back_to_back();
        stall_pct = 0;
        for (int k = 0; k < 4; k++)
            run_txn(k[0], 16'h0400, 8'd1, 1'b0, -1, 1'b0, 32'h0);
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        stall_pct = 0;
        early_last_en = 1'b0;
        early_last_beat = 0;
        drop_last_en = 1'b0;
        test_reset();
        test_single_write();
        test_burst_rw();
        test_out_of_range();
        test_throttle();
        test_reset_mid_burst();
        test_rlast_faults();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
